io_bus_controller: RTL and testbench
====================================

IO_BUS_CONTROLLER -- requirements
Module: io_bus_controller

Interface
REQ-001 The block SHALL use a single clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cpu_req  input  1  one-cycle request strobe from CPU; sampled only in IDLE.
REQ-005 cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 cpu_addr  input  16  word address; qualified by cpu_req.
REQ-007 cpu_wdata  input  16  write data; qualified by cpu_req.
REQ-008 cpu_rdata  output  16  read data; valid while cpu_ready=1.
REQ-009 cpu_ready  output  1  one-cycle completion pulse.
REQ-010 cpu_busy  output  1  high in any state other than IDLE.
REQ-011 ram_addr  output  8  RAM word address.
REQ-012 ram_we  output  1  RAM write enable.
REQ-013 ram_wdata  output  16  RAM write data.
REQ-014 ram_rdata  input  16  RAM read data, valid one cycle after ram_addr.
REQ-015 keypad_out  input  16  keypad status or data word.
REQ-016 statusordata  output  1  keypad select: 0 = status, 1 = data.
REQ-017 keypad_ack  output  1  one-cycle keypad consume pulse.
REQ-018 timer_out  input  16  timer ready flag or time value.
REQ-019 timeorready  output  1  timer select: 0 = ready, 1 = time.
REQ-020 timer_ack  output  1  one-cycle timer consume pulse.
REQ-021 seven_seg_data  output  16  display register.
REQ-022 bus_err  output  1  sticky error flag.

Function
REQ-023 The address map SHALL be:
- 0x0000-0x00FF: RAM.
- 0xFF00: KEYPAD_CHK (read).
- 0xFF01: KEYPAD_DAT (read).
- 0xFF02: SEVENSEG (read/write).
- 0xFF03: BUTTON_CHK (timer ready, read).
- 0xFF04: TIMER_DAT (read).
- All other addresses: unmapped.
REQ-024 The FSM SHALL have exactly four states: IDLE, SEL, CAPT, DONE.
REQ-025 In IDLE with cpu_req=1, the block SHALL latch cpu_addr, cpu_we and cpu_wdata, then go to SEL.
REQ-026 In SEL, the block SHALL drive ram_addr (low 8 bits), statusordata and timeorready from the latched address.
- Read: next state CAPT.
- Write: next state DONE.
REQ-027 On a RAM write, ram_we SHALL be 1 for exactly the SEL cycle, with ram_wdata equal to the latched write data.
REQ-028 A SEVENSEG write SHALL load seven_seg_data at the end of SEL.
REQ-029 Writes to read-only or unmapped addresses SHALL change no state and SHALL set bus_err.
REQ-030 CAPT SHALL latch the selected source into the read-data register, then go to DONE.
- Sources: ram_rdata, keypad_out, timer_out, or the seven_seg_data register.
- Unmapped read: latch 0x0000 and set bus_err.
REQ-031 In DONE, cpu_ready SHALL be 1 and cpu_rdata SHALL hold the captured word; next state is IDLE.
REQ-032 keypad_ack (for KEYPAD_DAT) and timer_ack (for TIMER_DAT) SHALL be 1 only in DONE. Status and ready reads SHALL NOT pulse any ack.
REQ-033 Latency from the cpu_req cycle to cpu_ready SHALL be 3 cycles for reads and 2 cycles for writes.
REQ-034 cpu_req asserted while cpu_busy=1 SHALL be ignored and SHALL set bus_err.
REQ-035 A new cpu_req in the cycle IDLE is re-entered after DONE SHALL be accepted normally.
REQ-036 statusordata and timeorready SHALL hold their value from SEL through DONE, then return to 0 in IDLE.
REQ-037 Outside DONE, cpu_rdata SHALL retain its last captured value.

Reset
REQ-038 On rst=1, the block SHALL:
- enter IDLE;
- clear cpu_ready, cpu_busy, ram_we, keypad_ack, timer_ack, statusordata, timeorready and bus_err;
- clear cpu_rdata and seven_seg_data to 0x0000.
REQ-039 Reset during any non-IDLE state SHALL abandon the transaction with no ready pulse, no ack pulse and no register or RAM update in the following cycles.
REQ-040 rst SHALL take priority over a simultaneous cpu_req.

Verification
REQ-041 Write 0x1234 to 0xFF02 -> seven_seg_data=0x1234 and cpu_ready=1 exactly 2 cycles after cpu_req; ram_we stays 0.
REQ-042 Read 0xFF01 with keypad_out=0x0007 -> statusordata=1 from SEL through DONE; cpu_rdata=0x0007 with cpu_ready 3 cycles after cpu_req; keypad_ack=1 in the same single cycle.
REQ-043 Write 0xBEEF to 0x0042, then read 0x0042 with ram_rdata model returning 0xBEEF:
- Write: ram_we pulses once with ram_addr=0x42.
- Read: cpu_rdata=0xBEEF.
REQ-044 Read 0x1000 -> cpu_rdata=0x0000, bus_err=1 and held until rst.
REQ-045 Read 0xFF04, then assert cpu_req in the SEL cycle -> second request ignored, bus_err=1, exactly one timer_ack pulse.
REQ-046 Assert rst in the CAPT cycle of a 0xFF01 read -> no keypad_ack and no cpu_ready; all outputs zero on the next cycle.

Source files
------------

// File: rtl/io_bus_controller.sv
// CPU-side bus controller: decodes RAM, keypad, seven-segment and timer accesses.
// Reads complete 3 cycles after cpu_req and writes 2 cycles after. A request made while busy is dropped and sets bus_err.
module io_bus_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_busy,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic [15:0] keypad_out,
    output logic        statusordata,
    output logic        keypad_ack,
    input  logic [15:0] timer_out,
    output logic        timeorready,
    output logic        timer_ack,
    output logic [15:0] seven_seg_data,
    output logic        bus_err
);

    localparam logic [15:0] ADDR_KEYPAD_CHK = 16'hFF00;
    localparam logic [15:0] ADDR_KEYPAD_DAT = 16'hFF01;
    localparam logic [15:0] ADDR_SEVENSEG   = 16'hFF02;
    localparam logic [15:0] ADDR_BUTTON_CHK = 16'hFF03;
    localparam logic [15:0] ADDR_TIMER_DAT  = 16'hFF04;

    typedef enum logic [1:0] {IDLE, SEL, CAPT, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] lat_addr;
    logic        lat_we;
    logic [15:0] lat_wdata;

    logic is_ram, is_kchk, is_kdat, is_seg, is_bchk, is_tdat;
    logic is_writable, is_mapped;

    always_comb begin
        is_ram      = (lat_addr[15:8] == 8'h00);
        is_kchk     = (lat_addr == ADDR_KEYPAD_CHK);
        is_kdat     = (lat_addr == ADDR_KEYPAD_DAT);
        is_seg      = (lat_addr == ADDR_SEVENSEG);
        is_bchk     = (lat_addr == ADDR_BUTTON_CHK);
        is_tdat     = (lat_addr == ADDR_TIMER_DAT);
        is_writable = is_ram | is_seg;
        is_mapped   = is_ram | is_kchk | is_kdat | is_seg | is_bchk | is_tdat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cpu_busy     = 1'b1;
        cpu_ready    = 1'b0;
        ram_we       = 1'b0;
        statusordata = 1'b0;
        timeorready  = 1'b0;
        keypad_ack   = 1'b0;
        timer_ack    = 1'b0;
        case (state)
            IDLE: begin
                cpu_busy = 1'b0;
                if (cpu_req) state_nxt = SEL;
            end
            SEL: begin
                statusordata = is_kdat;
                timeorready  = is_tdat;
                ram_we       = lat_we & is_ram;
                state_nxt    = lat_we ? DONE : CAPT;
            end
            CAPT: begin
                statusordata = is_kdat;
                timeorready  = is_tdat;
                state_nxt    = DONE;
            end
            DONE: begin
                statusordata = is_kdat;
                timeorready  = is_tdat;
                cpu_ready    = 1'b1;
                keypad_ack   = ~lat_we & is_kdat;
                timer_ack    = ~lat_we & is_tdat;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The RAM address stays on the bus through CAPT so the registered RAM read lands there.
    assign ram_addr  = lat_addr[7:0];
    assign ram_wdata = lat_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr       <= 16'h0000;
            lat_we         <= 1'b0;
            lat_wdata      <= 16'h0000;
            cpu_rdata      <= 16'h0000;
            seven_seg_data <= 16'h0000;
            bus_err        <= 1'b0;
        end else begin
            if (state == IDLE && cpu_req) begin
                lat_addr  <= cpu_addr;
                lat_we    <= cpu_we;
                lat_wdata <= cpu_wdata;
            end
            if (state != IDLE && cpu_req) bus_err <= 1'b1;
            if (state == SEL && lat_we) begin
                if (is_seg) seven_seg_data <= lat_wdata;
                if (!is_writable) bus_err <= 1'b1;
            end
            if (state == CAPT) begin
                if (is_ram)                 cpu_rdata <= ram_rdata;
                else if (is_kchk | is_kdat) cpu_rdata <= keypad_out;
                else if (is_bchk | is_tdat) cpu_rdata <= timer_out;
                else if (is_seg)            cpu_rdata <= seven_seg_data;
                else                        cpu_rdata <= 16'h0000;
                if (!is_mapped) bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller with a read-data/latency scoreboard and a registered RAM model.
module tb_io_bus_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [15:0] cpu_wdata = 16'h0000;
    logic [15:0] cpu_rdata;
    logic        cpu_ready, cpu_busy;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] keypad_out = 16'h0000;
    logic        statusordata, keypad_ack;
    logic [15:0] timer_out = 16'h0000;
    logic        timeorready, timer_ack;
    logic [15:0] seven_seg_data;
    logic        bus_err;

    io_bus_controller dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .keypad_out(keypad_out), .statusordata(statusordata), .keypad_ack(keypad_ack),
        .timer_out(timer_out), .timeorready(timeorready), .timer_ack(timer_ack),
        .seven_seg_data(seven_seg_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one cycle after the address.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int          kack_cnt = 0, tack_cnt = 0, we_cnt = 0, rdy_cnt = 0;
    logic [7:0]  last_we_addr = 8'h00;
    always @(posedge clk) begin
        if (keypad_ack) kack_cnt <= kack_cnt + 1;
        if (timer_ack)  tack_cnt <= tack_cnt + 1;
        if (cpu_ready)  rdy_cnt  <= rdy_cnt + 1;
        if (ram_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= ram_addr;
        end
    end

    typedef struct {
        logic [15:0] rd;
        int          lat;
        bit          is_rd;
    } exp_t;
    exp_t sb[$];

    int passed = 0, total = 0;
    bit sod_all, tor_all, kack_rdy, tack_rdy;
    int kack_d, tack_d, we_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return {cpu_rdata, cpu_ready, cpu_busy, ram_addr, ram_we, ram_wdata,
                statusordata, keypad_ack, timeorready, timer_ack, seven_seg_data, bus_err};
    endfunction

    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input bit poke);
        exp_t e, got;
        int   lat, k0, t0, w0;
        bit   seen;
        @(negedge clk);
        k0 = kack_cnt; t0 = tack_cnt; w0 = we_cnt;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        e.rd = exp_rd; e.lat = we ? 2 : 3; e.is_rd = !we;
        sb.push_back(e);
        sod_all = 1'b1; tor_all = 1'b1; kack_rdy = 1'b0; tack_rdy = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cpu_req = poke && (i == 0);
            cpu_we  = 1'b0;
            sod_all &= statusordata;
            tor_all &= timeorready;
            if (cpu_ready) begin
                seen = 1'b1;
                kack_rdy = keypad_ack;
                tack_rdy = timer_ack;
            end
        end
        cpu_req = 1'b0;
        chk("ready_seen", {63'd0, seen}, 64'd1);
        got = sb.pop_front();
        if (seen) begin
            chk("latency", lat, got.lat);
            if (got.is_rd) chk("rdata", {48'd0, cpu_rdata}, {48'd0, got.rd});
        end
        @(posedge clk);
        #1;
        kack_d = kack_cnt - k0;
        tack_d = tack_cnt - t0;
        we_d   = we_cnt - w0;
        chk("selects_idle", {62'd0, statusordata, timeorready}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_outs", all_outs(), 64'd0);
    endtask

    initial begin
        int k0, r0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_initial", all_outs(), 64'd0);
        rst = 1'b0;

        txn(1'b1, 16'hFF02, 16'h1234, 16'h0000, 1'b0);
        chk("seg_write", {48'd0, seven_seg_data}, 64'h1234);
        chk("seg_no_ram_we", we_d, 0);

        keypad_out = 16'h0007;
        txn(1'b0, 16'hFF01, 16'h0000, 16'h0007, 1'b0);
        chk("kdat_sod_held", {63'd0, sod_all}, 64'd1);
        chk("kdat_ack_with_ready", {63'd0, kack_rdy}, 64'd1);
        chk("kdat_ack_once", kack_d, 1);

        keypad_out = 16'h8001;
        txn(1'b0, 16'hFF00, 16'h0000, 16'h8001, 1'b0);
        chk("kchk_no_ack", kack_d, 0);

        txn(1'b1, 16'h0042, 16'hBEEF, 16'h0000, 1'b0);
        chk("ram_we_once", we_d, 1);
        chk("ram_we_addr", {56'd0, last_we_addr}, 64'h42);
        chk("rdata_retained", {48'd0, cpu_rdata}, 64'h8001);

        txn(1'b0, 16'h0042, 16'h0000, 16'hBEEF, 1'b0);
        txn(1'b0, 16'hFF02, 16'h0000, 16'h1234, 1'b0);

        timer_out = 16'h0001;
        txn(1'b0, 16'hFF03, 16'h0000, 16'h0001, 1'b0);
        chk("bchk_tor_zero", {63'd0, tor_all}, 64'd0);
        chk("bchk_no_ack", tack_d, 0);
        chk("no_err_back_to_back", {63'd0, bus_err}, 64'd0);

        timer_out = 16'h5555;
        k0 = tack_cnt;
        txn(1'b0, 16'hFF04, 16'h0000, 16'h5555, 1'b1);
        chk("tdat_tor_held", {63'd0, tor_all}, 64'd1);
        chk("tdat_ack_with_ready", {63'd0, tack_rdy}, 64'd1);
        chk("busy_req_err", {63'd0, bus_err}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_req_ignored", {63'd0, cpu_busy}, 64'd0);
        chk("tdat_ack_once", tack_cnt - k0, 1);

        do_reset();
        txn(1'b0, 16'h1000, 16'h0000, 16'h0000, 1'b0);
        chk("unmapped_rd_err", {63'd0, bus_err}, 64'd1);
        txn(1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b0);
        chk("err_sticky", {63'd0, bus_err}, 64'd1);

        do_reset();
        txn(1'b1, 16'hFF00, 16'hABCD, 16'h0000, 1'b0);
        chk("ro_write_err", {63'd0, bus_err}, 64'd1);
        chk("ro_write_seg", {48'd0, seven_seg_data}, 64'd0);
        chk("ro_write_no_we", we_d, 0);

        // Reset lands in the CAPT cycle of a keypad data read.
        do_reset();
        keypad_out = 16'h0007;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF01;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("capt_busy", {62'd0, cpu_busy, statusordata}, 64'd3);
        k0 = kack_cnt; r0 = rdy_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", all_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_ack", kack_cnt - k0, 0);
        chk("abort_no_ready", rdy_cnt - r0, 0);

        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0042;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        chk("rst_beats_req", {63'd0, cpu_busy}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
